// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MDU op codes, FSM states and
// the write-back source selects that now include HI and LO.
package mdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Write-back mux sources; mfhi/mflo select WD_HI/WD_LO.
    typedef enum logic [2:0] {
        WD_ALU = 3'd0,
        WD_MEM = 3'd1,
        WD_PC8 = 3'd2,
        WD_HI  = 3'd3,
        WD_LO  = 3'd4
    } wd_sel_e;

    // The hazard unit stalls later MDU instructions on Busy or on one of these.
    function automatic logic is_mult_div(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at accept time and committed when the latency counter expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_valid_q, pend_valid_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] div_s_b;
    logic [31:0] div_u_b;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor is forced to 1 for x/0 (result discarded anyway) and for
    // INT_MIN/-1, whose wrapped answer is exactly INT_MIN/1 with remainder 0.
    assign div_zero = (B == 32'd0);
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign div_s_b  = (div_zero || div_ovf) ? 32'd1 : B;
    assign div_u_b  = div_zero ? 32'd1 : B;

    assign quot_s = $signed(A) / $signed(div_s_b);
    assign rem_s  = $signed(A) % $signed(div_s_b);
    assign quot_u = A / div_u_b;
    assign rem_u  = A % div_u_b;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        MDU_MULT: begin
                            pend_hi_d    = prod_s[63:32];
                            pend_lo_d    = prod_s[31:0];
                            pend_valid_d = 1'b1;
                            count_d      = CNT_W'(MULT_CYCLES);
                            state_d      = ST_RUN;
                        end
                        MDU_MULTU: begin
                            pend_hi_d    = prod_u[63:32];
                            pend_lo_d    = prod_u[31:0];
                            pend_valid_d = 1'b1;
                            count_d      = CNT_W'(MULT_CYCLES);
                            state_d      = ST_RUN;
                        end
                        MDU_DIV: begin
                            pend_hi_d    = rem_s;
                            pend_lo_d    = quot_s;
                            pend_valid_d = !div_zero;
                            count_d      = CNT_W'(DIV_CYCLES);
                            state_d      = ST_RUN;
                        end
                        MDU_DIVU: begin
                            pend_hi_d    = rem_u;
                            pend_lo_d    = quot_u;
                            pend_valid_d = !div_zero;
                            count_d      = CNT_W'(DIV_CYCLES);
                            state_d      = ST_RUN;
                        end
                        MDU_MTHI: hi_d = A;
                        MDU_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d      = ST_IDLE;
                    pend_valid_d = 1'b0;
                    if (pend_valid_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a scoreboard of hand-derived HI/LO/latency values is
// pushed when each op is issued and popped when Busy drops.
module tb_mdu;
    import mdu_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 Clk = ~Clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    endtask

    task automatic apply_stimulus(input logic start, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
        Start = start;
        MDUOp = op;
        A     = a;
        B     = b;
    endtask

    // Issue one mult/div op at the current negedge and follow it to completion.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int cycles, input bit intrude);
        exp_t e;
        int   n;
        e.hi     = exp_hi;
        e.lo     = exp_lo;
        e.cycles = cycles;
        sb.push_back(e);
        apply_stimulus(1'b1, op, a, b);
        @(negedge Clk);
        if (intrude)
            apply_stimulus(1'b1, MDU_MULT, 32'd3, 32'd4);
        else
            apply_stimulus(1'b0, MDU_NONE, $urandom, $urandom);
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            check_output({name, "_hold_hi"}, HI, cur_hi);
            check_output({name, "_hold_lo"}, LO, cur_lo);
            n++;
            @(negedge Clk);
            apply_stimulus(1'b0, MDU_NONE, $urandom, $urandom);
        end
        e = sb.pop_front();
        check_output({name, "_busy_len"}, 32'(n), 32'(e.cycles));
        check_output({name, "_hi"}, HI, e.hi);
        check_output({name, "_lo"}, LO, e.lo);
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    initial begin
        Reset = 1'b1;
        apply_stimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check_output("reset_busy", 32'(Busy), 32'd0);
        check_output("reset_hi", HI, 32'd0);
        check_output("reset_lo", LO, 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        apply_stimulus(1'b1, MDU_NONE, 32'd5, 32'd6);
        @(negedge Clk);
        apply_stimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
        check_output("none_busy", 32'(Busy), 32'd0);
        check_output("none_hi", HI, 32'd0);
        check_output("none_lo", LO, 32'd0);

        run_op("mult_m2x3",  MDU_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0);
        run_op("multu_max",  MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, 1'b0);
        run_op("mult_min2",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5, 1'b0);
        run_op("mult_7xm1",  MDU_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 5, 1'b0);
        run_op("div_m7_2",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
        run_op("div_m7_m2",  MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10, 1'b0);
        run_op("div_7_m2",   MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, 1'b0);
        run_op("div_ovf",    MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 1'b0);
        run_op("divu_big",   MDU_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 10, 1'b0);
        run_op("divu_7_2",   MDU_DIVU,  32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 10, 1'b0);
        run_op("div_by0",    MDU_DIV,   32'd5,         32'd0,        32'h0000_0001, 32'h0000_0003, 10, 1'b0);

        apply_stimulus(1'b1, MDU_MTHI, 32'h1234_5678, 32'd0);
        @(negedge Clk);
        check_output("mthi_busy", 32'(Busy), 32'd0);
        check_output("mthi_hi", HI, 32'h1234_5678);
        check_output("mthi_lo_kept", LO, 32'h0000_0003);
        apply_stimulus(1'b1, MDU_MTLO, 32'hCAFE_BABE, 32'd0);
        @(negedge Clk);
        apply_stimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
        check_output("mtlo_busy", 32'(Busy), 32'd0);
        check_output("mtlo_lo", LO, 32'hCAFE_BABE);
        check_output("mtlo_hi_kept", HI, 32'h1234_5678);
        cur_hi = 32'h1234_5678;
        cur_lo = 32'hCAFE_BABE;

        run_op("div_100_7", MDU_DIV, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 10, 1'b1);

        apply_stimulus(1'b1, MDU_DIVU, 32'd1000, 32'd3);
        @(negedge Clk);
        apply_stimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
        check_output("rst_mid_busy_on", 32'(Busy), 32'd1);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_output("rst_mid_busy", 32'(Busy), 32'd0);
        check_output("rst_mid_hi", HI, 32'd0);
        check_output("rst_mid_lo", LO, 32'd0);
        repeat (12) @(negedge Clk);
        check_output("rst_late_busy", 32'(Busy), 32'd0);
        check_output("rst_late_hi", HI, 32'd0);
        check_output("rst_late_lo", LO, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the MIPS core. It consumes the same GRF read data (rs, rt) the ALU receives and produces HI/LO values for `mfhi`/`mflo` write-back through the `grf_wd` mux. It models MIPS latency: multiply occupies 5 cycles and divide 10 cycles. While Busy is asserted, the pipeline control stalls any later MDU instruction.

## Interface

Parameters:

- `MULT_CYCLES`, default 5: busy duration for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy duration for `div`/`divu`.

Ports:

- `Clk`, input, 1: clock. All state changes on the rising edge.
- `Reset`, input, 1: synchronous, active-high.
- `Start`, input, 1: qualifies `MDUOp` for one cycle.
- `MDUOp`, input, 3: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`, `MDU_MTHI`, `MDU_MTLO`. `MDU_NONE` = 0.
- `A`, input, 32: operand rs.
- `B`, input, 32: operand rt.
- `Busy`, output, 1: operation in flight.
- `HI`, output, 32: architectural HI register.
- `LO`, output, 32: architectural LO register.

## Operation

- Reset: `HI`=0, `LO`=0, `Busy`=0, cycle counter=0, pending result cleared.
- Accept condition: `Start`=1 and `Busy`=0 at a clock edge. `Start` while `Busy`=1 is ignored with no state change.
- `MULT`: signed 32×32 → 64-bit product. Upper 32 bits go to HI, lower 32 bits to LO.
- `MULTU`: the same, with operands treated as unsigned.
- `DIV`: signed division. Quotient → LO, remainder → HI. Truncate toward zero; the remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `DIVU`: unsigned division. Quotient → LO, remainder → HI.
- Divide by zero (`B`=0): the op is accepted and `Busy` runs for the full `DIV_CYCLES`. At completion HI/LO keep their previous values.
- `MTHI`/`MTLO`: HI (or LO) ← `A` on the accept edge. `Busy` stays 0.
- `MDU_NONE` with `Start`=1: no effect.
- The result is computed from `A`/`B` sampled on the accept edge and held in pending registers. Operand changes after that edge have no effect.
- States: IDLE (counter=0) and RUN (counter>0).
  - IDLE → RUN on accepting a mult/div op. The counter loads the cycle count.
  - RUN: the counter decrements on each edge. On the edge where counter=1, HI/LO are loaded from the pending registers, the counter goes to 0 and the state returns to IDLE.
- Reset mid-operation: counter, `Busy`, HI and LO all clear on that edge. The pending result is discarded.

## Timing

- `Busy` rises in the cycle after the accept edge and is high for exactly `MULT_CYCLES` or `DIV_CYCLES` cycles.
- HI/LO change on the same edge that `Busy` falls. They hold their old values for the whole busy window.
- A new op can be accepted on the first edge where `Busy`=0. This means back-to-back ops are spaced N+1 edges apart.
- `MTHI`/`MTLO` latency is 1 edge. The new value is visible on `HI`/`LO` in the following cycle.
- `HI`/`LO`/`Busy` are registered outputs with no combinational path from the inputs.
- The counter is 4 bits wide. Parameters above 15 are illegal.

## Structure

- Add `MDU_*` op codes to `header.v` next to the existing ALU/`wd_*` defines. Add a new `wd_hi`/`wd_lo` selection to the write-back mux encoding.
- The controller decodes `MDUOp` and `Start`. The hazard unit stalls on `Busy | (Start & MDUOp is mult/div)` for any subsequent MDU instruction.
- Single module, no sub-module. The arithmetic uses the behavioural `*`, `/` and `%` operators, whose results feed the pending registers.

## Test plan

- Reset, then `MULT` with A=0xFFFFFFFE (−2), B=3: `Busy` is high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA. HI/LO stay 0 throughout the busy window.
- `MULTU` with A=0xFFFFFFFF, B=0xFFFFFFFF: after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- `DIV` with A=−7 (0xFFFFFFF9), B=2: `Busy` is high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- `DIVU` with A=7, B=2, followed by `DIV` with A=5, B=0:
  - After the `DIVU`: LO=3, HI=1.
  - The `DIV` keeps `Busy` high for 10 cycles, and HI/LO remain 1/3.
- `MTHI` A=0x12345678, then `MTLO` A=0xCAFEBABE on consecutive edges: `Busy` never rises, and HI/LO update one edge after each.
- Start `DIV` 100/7 and assert `Start`+`MULT` during the busy window, then assert `Reset` on busy cycle 4:
  - The `MULT` is ignored.
  - After `Reset`: `Busy`=0, HI=LO=0, and no late write occurs.
